// File: rtl/eq_pwm_feeder_pkg.sv
// Shared constants for the equalizer-to-PWM feeder: level format, clip limits, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eq_pwm_feeder_pkg;

    // Output level: unsigned, offset-binary around midscale (silence).
    localparam int                 LEVEL_W  = 20;
    localparam logic [LEVEL_W-1:0] MIDSCALE = 20'h80000;

    // Signed 20-bit clip window applied after the mix is scaled down.
    localparam logic signed [31:0] SAT_MAX  = 32'sd524287;
    localparam logic signed [31:0] SAT_MIN  = -32'sd524288;

    // Mixer FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;
    localparam logic [1:0] ST_PUSH = 2'd3;

endpackage

// File: rtl/eq_sample_fifo.sv
// Small level buffer between the mixer and the PWM frame pop; show-ahead read data.
// Latency: a push is visible on data/empty the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together both apply.
//
// Ports: clk, reset (sync, active-high); push/push_data write side;
//        pop/data read side; full, empty status.
module eq_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign data  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/eq_pwm_feeder.sv
// Mixes three gained equalizer bands into one PWM level and hands one level per PWM frame.
// Latency: transfer -> FIFO entry 5 cycles; FIFO -> pwm_data at the next frame boundary.
// Backpressure: in_ready low while a mix is in flight or the level FIFO is full.
//
// Ports: clk, reset (sync, active-high); band0..2 signed samples, gain0..2 Q2.2 gains,
//        in_valid/in_ready handshake; pwm_data/pwm_ready level output;
//        sat_flag, underrun_flag sticky status cleared by flag_clr.
module eq_pwm_feeder
    import eq_pwm_feeder_pkg::*;
#(
    parameter int N           = 25,
    parameter int W_IN        = 24,
    parameter int PERIOD_LOG2 = 20,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [W_IN-1:0] band0,
    input  logic signed [W_IN-1:0] band1,
    input  logic signed [W_IN-1:0] band2,
    input  logic [3:0]             gain0,
    input  logic [3:0]             gain1,
    input  logic [3:0]             gain2,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N-1:0]           pwm_data,
    output logic                   pwm_ready,
    output logic                   sat_flag,
    output logic                   underrun_flag,
    input  logic                   flag_clr
);

    // Three products of W_IN+4 bits each fit comfortably in W_IN+6.
    localparam int ACC_W = W_IN + 6;

    logic [1:0]               state;
    logic [1:0]               band_idx;
    logic signed [W_IN-1:0]   band_q [3];
    logic [3:0]               gain_q [3];
    logic signed [ACC_W-1:0]  acc;
    logic signed [W_IN-1:0]   mac_band;
    logic [3:0]               mac_gain;
    logic signed [W_IN+4:0]   mac_prod;
    logic signed [31:0]       shifted;
    logic [LEVEL_W-1:0]       clipped;
    logic                     clip_hit;
    logic [LEVEL_W-1:0]       level;
    logic [LEVEL_W-1:0]       level_q;
    logic                     transfer;

    logic [LEVEL_W-1:0]       fifo_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;

    logic [PERIOD_LOG2-1:0]   frame_cnt;
    logic                     boundary;
    logic [LEVEL_W-1:0]       pwm_level;

    // Gated by reset so the block advertises nothing while held in reset.
    assign in_ready = !reset && (state == ST_IDLE) && !fifo_full;
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (transfer) begin
            band_q[0] <= band0;
            band_q[1] <= band1;
            band_q[2] <= band2;
            gain_q[0] <= gain0;
            gain_q[1] <= gain1;
            gain_q[2] <= gain2;
        end
    end

    // One band per MAC cycle through a single multiplier.
    always_comb begin
        mac_band = band_q[0];
        mac_gain = gain_q[0];
        case (band_idx)
            2'd1: begin
                mac_band = band_q[1];
                mac_gain = gain_q[1];
            end
            2'd2: begin
                mac_band = band_q[2];
                mac_gain = gain_q[2];
            end
            default: ;
        endcase
    end

    // Gain is unsigned; a zero MSB keeps the signed multiply correct.
    assign mac_prod = mac_band * $signed({1'b0, mac_gain});

    // Drop the Q2.2 fraction plus the extra headroom, then clip to 20 bits.
    assign shifted = 32'(acc) >>> 6;

    always_comb begin
        clip_hit = 1'b0;
        clipped  = LEVEL_W'(shifted);
        if (shifted > SAT_MAX) begin
            clipped  = LEVEL_W'(SAT_MAX);
            clip_hit = 1'b1;
        end else if (shifted < SAT_MIN) begin
            clipped  = LEVEL_W'(SAT_MIN);
            clip_hit = 1'b1;
        end
    end

    // Signed-to-offset-binary conversion.
    assign level = clipped + MIDSCALE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            band_idx <= '0;
            acc      <= '0;
            level_q  <= MIDSCALE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        state    <= ST_MAC;
                        band_idx <= '0;
                        acc      <= '0;
                    end
                end
                ST_MAC: begin
                    acc      <= acc + ACC_W'(mac_prod);
                    band_idx <= band_idx + 2'd1;
                    if (band_idx == 2'd2) state <= ST_SAT;
                end
                ST_SAT: begin
                    level_q <= level;
                    state   <= ST_PUSH;
                end
                ST_PUSH: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_push = (state == ST_PUSH);

    eq_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LEVEL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (level_q),
        .pop       (fifo_pop),
        .data      (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame counter wraps naturally at 2^PERIOD_LOG2.
    always_ff @(posedge clk) begin
        if (reset) frame_cnt <= '0;
        else       frame_cnt <= frame_cnt + PERIOD_LOG2'(1);
    end

    assign boundary = (frame_cnt == '1);
    assign fifo_pop = boundary && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_level <= MIDSCALE;
            pwm_ready <= 1'b0;
        end else begin
            pwm_ready <= fifo_pop;
            if (fifo_pop) pwm_level <= fifo_data;
        end
    end

    // Set beats clear when both land on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag      <= 1'b0;
            underrun_flag <= 1'b0;
        end else begin
            if (state == ST_SAT && clip_hit) sat_flag <= 1'b1;
            else if (flag_clr)               sat_flag <= 1'b0;
            if (boundary && fifo_empty)      underrun_flag <= 1'b1;
            else if (flag_clr)               underrun_flag <= 1'b0;
        end
    end

    assign pwm_data = {{(N-LEVEL_W){1'b0}}, pwm_level};

endmodule

// File: tb/tb_eq_pwm_feeder.sv
// Self-checking bench for eq_pwm_feeder with a 16-cycle PWM frame.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_eq_pwm_feeder;

    localparam int N     = 25;
    localparam int W_IN  = 24;
    localparam int PL    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [W_IN-1:0] band0 = '0, band1 = '0, band2 = '0;
    logic [3:0]      gain0 = '0, gain1 = '0, gain2 = '0;
    logic            in_valid = 1'b0;
    logic            flag_clr = 1'b0;
    logic            in_ready;
    logic [N-1:0]    pwm_data;
    logic            pwm_ready;
    logic            sat_flag;
    logic            underrun_flag;

    always #5 clk = ~clk;

    eq_pwm_feeder #(
        .N           (N),
        .W_IN        (W_IN),
        .PERIOD_LOG2 (PL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .band0         (band0),
        .band1         (band1),
        .band2         (band2),
        .gain0         (gain0),
        .gain1         (gain1),
        .gain2         (gain2),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pwm_data      (pwm_data),
        .pwm_ready     (pwm_ready),
        .sat_flag      (sat_flag),
        .underrun_flag (underrun_flag),
        .flag_clr      (flag_clr)
    );

    int ncmp = 0;
    int nbad = 0;
    int pulses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Mix level from first principles: sum of band*gain, drop 6 bits, clip, offset to midscale.
    function automatic logic [19:0] level_of(input logic [W_IN-1:0] b0, input logic [W_IN-1:0] b1,
                                             input logic [W_IN-1:0] b2, input logic [3:0] g0,
                                             input logic [3:0] g1, input logic [3:0] g2,
                                             output bit clipped);
        longint s;
        longint sh;
        s = longint'($signed(b0)) * longint'(g0)
          + longint'($signed(b1)) * longint'(g1)
          + longint'($signed(b2)) * longint'(g2);
        sh = s >>> 6;
        clipped = 1'b0;
        if (sh > 524287) begin
            sh = 524287;
            clipped = 1'b1;
        end else if (sh < -524288) begin
            sh = -524288;
            clipped = 1'b1;
        end
        return 20'(sh + 524288);
    endfunction

    // Behavioural model: a job timeline plus a queue of levels waiting for frame boundaries.
    int          q[$];
    bit          job_act = 1'b0;
    int          job_t0 = 0;
    logic [19:0] job_lvl = '0;
    bit          job_sat = 1'b0;
    logic [19:0] m_data = 20'h80000;
    bit          m_rdy = 1'b0, m_sat = 1'b0, m_und = 1'b0;
    bit          m_valid = 1'b0;
    int          ecnt = 0;

    always @(posedge clk) begin
        bit rdy_pre;
        bit sat_set;
        bit und_set;
        if (reset) begin
            q.delete();
            job_act = 1'b0;
            m_data  = 20'h80000;
            m_rdy   = 1'b0;
            m_sat   = 1'b0;
            m_und   = 1'b0;
            ecnt    = 0;
            m_valid = 1'b1;
        end else begin
            rdy_pre = !job_act && (q.size() < DEPTH);
            sat_set = 1'b0;
            und_set = 1'b0;
            m_rdy   = 1'b0;
            if (ecnt % FRAME == FRAME - 1) begin
                if (q.size() > 0) begin
                    m_data = 20'(q.pop_front());
                    m_rdy  = 1'b1;
                end else begin
                    und_set = 1'b1;
                end
            end
            if (job_act && ecnt == job_t0 + 4 && job_sat) sat_set = 1'b1;
            if (job_act && ecnt == job_t0 + 5) begin
                q.push_back(int'(job_lvl));
                job_act = 1'b0;
            end
            if (in_valid && rdy_pre) begin
                job_act = 1'b1;
                job_t0  = ecnt;
                job_lvl = level_of(band0, band1, band2, gain0, gain1, gain2, job_sat);
            end
            if (sat_set)       m_sat = 1'b1;
            else if (flag_clr) m_sat = 1'b0;
            if (und_set)       m_und = 1'b1;
            else if (flag_clr) m_und = 1'b0;
            ecnt++;
        end
    end

    // Every-cycle comparison against the model, well clear of the rising edge.
    always @(negedge clk) begin
        #2;
        if (m_valid) begin
            chk("pwm_data", 64'(pwm_data), 64'({5'b0, m_data}));
            chk("pwm_ready", 64'(pwm_ready), 64'(m_rdy));
            chk("sat_flag", 64'(sat_flag), 64'(m_sat));
            chk("underrun_flag", 64'(underrun_flag), 64'(m_und));
            chk("in_ready", 64'(in_ready), 64'(!reset && !job_act && (q.size() < DEPTH)));
        end
    end

    always @(negedge clk) begin
        if (pwm_ready === 1'b1) pulses++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        flag_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W_IN-1:0] b0, input logic [W_IN-1:0] b1, input logic [W_IN-1:0] b2,
                        input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2,
                        output int acc_edge);
        bit t;
        bit ok;
        #1;
        band0 = b0; band1 = b1; band2 = b2;
        gain0 = g0; gain1 = g1; gain2 = g2;
        in_valid = 1'b1;
        acc_edge = -1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            t = in_ready;
            if (t) acc_edge = ecnt;
            @(negedge clk);
            #1;
            if (t) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_pulse(input string nm);
        int p0;
        p0 = pulses;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (pulses != p0) break;
        end
        chk(nm, 64'(pulses - p0), 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          ae;
        int          acc_e[6];
        int          p0;
        bit          c;
        logic [19:0] l;
        logic [19:0] exp_last;
        logic [W_IN-1:0] rb[3];
        logic [3:0]      rg[3];
        logic [W_IN-1:0] bb[3];

        // Pin the reference model with hand-computed mixes.
        l = level_of(24'h000000, 24'h000000, 24'h000000, 4'd9, 4'd3, 4'd15, c);
        chk("model_zero", 64'(l), 64'h80000);
        l = level_of(24'h100000, 24'h000000, 24'h000000, 4'd4, 4'd0, 4'd0, c);
        chk("model_unity", 64'(l), 64'h90000);
        chk("model_unity_sat", 64'(c), 64'd0);
        l = level_of(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 4'd15, 4'd15, 4'd15, c);
        chk("model_posfull", 64'(l), 64'hFFFFF);
        chk("model_posfull_sat", 64'(c), 64'd1);
        l = level_of(24'h800000, 24'h800000, 24'h800000, 4'd15, 4'd15, 4'd15, c);
        chk("model_negfull", 64'(l), 64'h00000);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        chk("reset_pwm_data", 64'(pwm_data), 64'h80000);

        // Silent mix: one pulse, midscale level.
        send('0, '0, '0, 4'd7, 4'd2, 4'd11, ae);
        wait_pulse("zero_pulse");
        chk("zero_level", 64'(pwm_data), 64'h80000);
        p0 = pulses;
        wait_cycles(40);
        chk("zero_single_pulse", 64'(pulses - p0), 64'd0);

        // Unity gain on band0.
        do_reset();
        send(24'h100000, '0, '0, 4'd4, 4'd0, 4'd0, ae);
        wait_pulse("unity_pulse");
        chk("unity_level", 64'(pwm_data), 64'h90000);
        chk("unity_no_sat", 64'(sat_flag), 64'd0);

        // Positive and negative full scale clip.
        send(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 4'd15, 4'd15, 4'd15, ae);
        wait_pulse("posfull_pulse");
        chk("posfull_level", 64'(pwm_data), 64'hFFFFF);
        chk("posfull_sat", 64'(sat_flag), 64'd1);
        flag_clr = 1'b1;
        wait_cycles(1);
        flag_clr = 1'b0;
        chk("sat_cleared", 64'(sat_flag), 64'd0);
        send(24'h800000, 24'h800000, 24'h800000, 4'd15, 4'd15, 4'd15, ae);
        wait_pulse("negfull_pulse");
        chk("negfull_level", 64'(pwm_data), 64'h00000);
        chk("negfull_sat", 64'(sat_flag), 64'd1);

        // Back-to-back burst fills the FIFO; the sixth sample waits for a pop.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bb[0] = W_IN'($urandom); bb[1] = W_IN'($urandom); bb[2] = W_IN'($urandom);
            send(bb[0], bb[1], bb[2], 4'd1, 4'd2, 4'd3, acc_e[k]);
        end
        exp_last = level_of(bb[0], bb[1], bb[2], 4'd1, 4'd2, 4'd3, c);
        chk("burst_fifth_edge", 64'(acc_e[4]), 64'd24);
        chk("burst_sixth_edge", 64'(acc_e[5]), 64'd32);

        // Starve the output: level holds, underrun sticks, then clears.
        wait_cycles(100);
        p0 = pulses;
        wait_cycles(2 * FRAME);
        chk("starve_no_pulse", 64'(pulses - p0), 64'd0);
        chk("starve_hold", 64'(pwm_data), 64'(exp_last));
        chk("starve_underrun", 64'(underrun_flag), 64'd1);
        for (int i = 0; i < FRAME && (ecnt % FRAME) != 4; i++) wait_cycles(1);
        flag_clr = 1'b1;
        wait_cycles(1);
        flag_clr = 1'b0;
        chk("underrun_cleared", 64'(underrun_flag), 64'd0);

        // Reset while mixing drops the sample.
        do_reset();
        send(24'h123456, 24'h054321, 24'h0ABCDE, 4'd5, 4'd6, 4'd7, ae);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        p0 = pulses;
        wait_cycles(40);
        chk("midmac_no_pulse", 64'(pulses - p0), 64'd0);
        chk("midmac_level", 64'(pwm_data), 64'h80000);
        chk("midmac_ready", 64'(in_ready), 64'd1);
        chk("midmac_fifo_empty", 64'(underrun_flag), 64'd1);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            for (int j = 0; j < 3; j++) begin
                case ($urandom_range(0, 3))
                    0:       rb[j] = W_IN'($urandom);
                    1:       rb[j] = ($urandom_range(0, 1) == 0) ? 24'h7FFFFF : 24'h800000;
                    2:       rb[j] = W_IN'(int'($urandom_range(0, 4095)) - 2048);
                    default: rb[j] = W_IN'($urandom_range(0, 24'h0FFFFF));
                endcase
                rg[j] = 4'($urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 4)) begin
                flag_clr = ($urandom_range(0, 7) == 0);
                wait_cycles(1);
            end
            flag_clr = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                send(rb[0], rb[1], rb[2], rg[0], rg[1], rg[2], ae);
                reset = 1'b1;
                wait_cycles(1);
                reset = 1'b0;
            end else begin
                send(rb[0], rb[1], rb[2], rg[0], rg[1], rg[2], ae);
            end
        end
        wait_cycles(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
